// File: rtl/regfile_32x32_pkg.sv
// Shared constants and types for the 32-entry GPR array.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W = 5;
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    // Default register word; modules with a WIDTH parameter define their own local word type.
    typedef logic [31:0] reg_word_t;

endpackage

// File: rtl/decoder.sv
// 5-to-32 one-hot decoder used as the register-file write select.
module decoder (
    input  logic [4:0]  iData,
    input  logic        iEna,
    output logic [31:0] oData
);

    // One-hot output when enabled. An unknown index leaves every bit clear, so a corrupt
    // address can never turn into several simultaneous writes.
    always_comb begin
        oData = '0;
        if (iEna) begin
            oData[iData] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_32x32_reg_cell.sv
// Single WIDTH-bit register with asynchronous clear and load enable.
module reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Clear immediately on reset; otherwise load d only on enabled edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (ena) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_32x32.sv
// 32 x WIDTH register file: two combinational read ports, one synchronous write port.
// Write selection comes from the one-hot decoder, so at most one register loads per edge.
module regfile_32x32
    import regfile_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata1,
    output logic [WIDTH-1:0]  rdata2
);

    typedef logic [WIDTH-1:0] word_t;

    logic [NUM_REGS-1:0] wsel;
    logic [NUM_REGS-1:0] cellEna;
    word_t               regQ [NUM_REGS];
    logic                bypassHit1;
    logic                bypassHit2;

    decoder uDecoder (
        .iData (waddr),
        .iEna  (we),
        .oData (wsel)
    );

    // Register 0 never loads when it is hardwired; its cell is left for synthesis to prune.
    always_comb begin
        cellEna = wsel;
        if (ZERO_R0) begin
            cellEna[REG_ZERO] = 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : gCell
            reg_cell #(
                .WIDTH (WIDTH)
            ) uCell (
                .clk (clk),
                .rst (rst),
                .ena (cellEna[i]),
                .d   (wdata),
                .q   (regQ[i])
            );
        end
    endgenerate

    // Write-through detection; never forwards into a hardwired register 0.
    always_comb begin
        bypassHit1 = BYPASS && we && (raddr1 == waddr) && !(ZERO_R0 && raddr1 == REG_ZERO);
        bypassHit2 = BYPASS && we && (raddr2 == waddr) && !(ZERO_R0 && raddr2 == REG_ZERO);
    end

    // Read port 1: zero during reset and for hardwired r0, else forwarded or stored value.
    always_comb begin
        rdata1 = regQ[raddr1];
        if (rst || (ZERO_R0 && raddr1 == REG_ZERO)) begin
            rdata1 = '0;
        end else if (bypassHit1) begin
            rdata1 = wdata;
        end
    end

    // Read port 2: same rules as port 1, fully independent address.
    always_comb begin
        rdata2 = regQ[raddr2];
        if (rst || (ZERO_R0 && raddr2 == REG_ZERO)) begin
            rdata2 = '0;
        end else if (bypassHit2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: tb/tb_regfile_32x32.sv
// Bench for regfile_32x32: three parameter variants driven in parallel, a behavioural
// array model checked every falling edge, plus directed literal expectations.
module tb_regfile_32x32;

    localparam int NDUT = 3;
    // Variant 0: ZERO_R0=1 BYPASS=0, variant 1: ZERO_R0=0 BYPASS=1, variant 2: both 1.
    localparam bit ZR [NDUT] = '{1'b1, 1'b0, 1'b1};
    localparam bit BP [NDUT] = '{1'b0, 1'b1, 1'b1};

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rd1 [NDUT];
    logic [31:0] rd2 [NDUT];

    logic [31:0] mem [NDUT][32] = '{default: '0};

    int nChecks = 0;
    int nPass = 0;

    regfile_32x32 #(.WIDTH(32), .ZERO_R0(1'b1), .BYPASS(1'b0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[0]), .rdata2(rd2[0])
    );
    regfile_32x32 #(.WIDTH(32), .ZERO_R0(1'b0), .BYPASS(1'b1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[1]), .rdata2(rd2[1])
    );
    regfile_32x32 #(.WIDTH(32), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut2 (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1[2]), .rdata2(rd2[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) begin
            nPass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: an array of words, cleared by reset, written on clock edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NDUT; k++)
                for (int r = 0; r < 32; r++) mem[k][r] = '0;
        end else if (we) begin
            for (int k = 0; k < NDUT; k++)
                if (!(ZR[k] && waddr == 5'd0)) mem[k][waddr] = wdata;
        end
    end

    function automatic logic [31:0] expRead(input int k, input logic [4:0] a);
        if (rst) return '0;
        if (ZR[k] && a == 5'd0) return '0;
        if (BP[k] && we && a == waddr) return wdata;
        return mem[k][a];
    endfunction

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("model rdata1 dut%0d", k), rd1[k], expRead(k, raddr1));
            check($sformatf("model rdata2 dut%0d", k), rd2[k], expRead(k, raddr2));
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        waddr = a;
        wdata = d;
        we = 1'b1;
        @(posedge clk);
        #2;
        we = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        raddr1 = '0;
        raddr2 = '0;
        #12;
        rst = 1'b0;

        // Reset state
        raddr1 = 5'd5;
        raddr2 = 5'd31;
        #1;
        check("reset rdata1", rd1[0], 32'h0);
        check("reset rdata2", rd2[2], 32'h0);

        // Preload then asynchronous reset between edges
        wr(5'd5, 32'hDEADBEEF);
        #1;
        for (int k = 0; k < NDUT; k++) check($sformatf("preload r5 dut%0d", k), rd1[k], 32'hDEADBEEF);
        rst = 1'b1;
        #1;
        for (int k = 0; k < NDUT; k++) check($sformatf("async rst r5 dut%0d", k), rd1[k], 32'h0);
        #2;
        rst = 1'b0;

        // Basic write/read on both ports, then scan all 32
        wr(5'd7, 32'h12345678);
        raddr1 = 5'd7;
        raddr2 = 5'd7;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("r7 port1 dut%0d", k), rd1[k], 32'h12345678);
            check($sformatf("r7 port2 dut%0d", k), rd2[k], 32'h12345678);
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            #1;
            check($sformatf("scan r%0d", i), rd1[0], (i == 7) ? 32'h12345678 : 32'h0);
        end

        // we=0 hold over three edges
        waddr = 5'd7;
        wdata = 32'hFFFFFFFF;
        we = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        raddr1 = 5'd7;
        #1;
        check("hold r7", rd1[0], 32'h12345678);

        // Register 0 protection
        wr(5'd0, 32'hAAAA5555);
        raddr1 = 5'd0;
        #1;
        check("r0 zero dut0", rd1[0], 32'h0);
        check("r0 stored dut1", rd1[1], 32'hAAAA5555);
        check("r0 zero dut2", rd1[2], 32'h0);

        // Same-cycle read/write
        wr(5'd3, 32'h1);
        waddr = 5'd3;
        wdata = 32'h2;
        we = 1'b1;
        raddr1 = 5'd3;
        #1;
        check("same-cycle nobypass", rd1[0], 32'h1);
        check("same-cycle bypass dut1", rd1[1], 32'h2);
        check("same-cycle bypass dut2", rd1[2], 32'h2);
        @(posedge clk);
        #2;
        we = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) check($sformatf("after edge r3 dut%0d", k), rd1[k], 32'h2);

        // Bypass to index 0: forwarded only when r0 is a real register
        waddr = 5'd0;
        wdata = 32'h55;
        we = 1'b1;
        raddr1 = 5'd0;
        #1;
        check("bypass r0 dut0", rd1[0], 32'h0);
        check("bypass r0 dut1", rd1[1], 32'h55);
        check("bypass r0 dut2", rd1[2], 32'h0);
        @(posedge clk);
        #2;
        we = 1'b0;

        // Walking write 1..31 on consecutive edges
        for (int i = 1; i < 32; i++) begin
            waddr = 5'(i);
            wdata = 32'(i + 100);
            we = 1'b1;
            @(posedge clk);
            #2;
        end
        we = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            check($sformatf("walk p1 r%0d dut0", i), rd1[0], (i == 0) ? 32'h0 : 32'(i + 100));
            check($sformatf("walk p2 r%0d dut0", 31 - i), rd2[0], (i == 31) ? 32'h0 : 32'(131 - i));
            check($sformatf("walk p1 r%0d dut1", i), rd1[1], (i == 0) ? 32'h55 : 32'(i + 100));
            check($sformatf("walk p2 r%0d dut2", 31 - i), rd2[2], (i == 31) ? 32'h0 : 32'(131 - i));
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/regfile_32x32.md
Name: regfile_32x32

Overview:
- 32-entry by 32-bit register file with two asynchronous read ports and one synchronous write port.
- Sits directly downstream of the 5-to-32 one-hot write decoder and consumes its 32-bit one-hot output as per-register write enables.
- Storage element for the CPU datapath labs (MIPS-style GPR array).

Parameters:
- WIDTH, 32, data width of each register.
- ZERO_R0, 1, when 1 register 0 is hardwired to zero and writes to it are discarded.
- BYPASS, 0, when 1 a read of the address being written this cycle returns wdata (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable, sampled on rising edge of clk.
- waddr  input  5  write register index.
- wdata  input  WIDTH  write data.
- raddr1  input  5  read port 1 index.
- raddr2  input  5  read port 2 index.
- rdata1  output  WIDTH  read port 1 data, combinational.
- rdata2  output  WIDTH  read port 2 data, combinational.

Behaviour:
- Reset: rst high clears all 32 registers to 0 immediately, without waiting for clk. rdata1 and rdata2 read 0 while rst is high. Reset deasserted mid-cycle resumes writes from the next rising edge.
- Write decode: the existing module decoder (iData=waddr, iEna=we, oData=wsel[31:0]) produces a one-hot wsel.
  - On the rising edge of clk with rst low, register i loads wdata iff wsel[i]=1.
  - All other registers hold their value.
  - Write latency is 1 cycle, and a written value is visible on the read ports after that edge.
- we=0: wsel is all zero and no register changes.
- ZERO_R0=1:
  - A write with waddr=0 is ignored.
  - Reading index 0 returns 0 regardless of any prior write.
  - Register 0 storage may be optimised away.
- Reads:
  - Purely combinational. rdata1 = reg[raddr1] and rdata2 = reg[raddr2].
  - Both ports are independent and may address the same register.
- Same-cycle read/write to the same index:
  - BYPASS=0: the read returns the old value until the edge.
  - BYPASS=1: the read returns wdata while we=1 and waddr==raddr. This does not apply to index 0 when ZERO_R0=1.
- Widths: no arithmetic is performed. wdata is stored unmodified, and all 5-bit indices are valid with no out-of-range case.
- X-handling: a write with we=1 and waddr containing X must not be synthesised into multiple writes. The decoder guarantees a one-hot output, so at most one register is written per cycle.

Decomposition:
- Shared package (regfile_pkg):
  - Constants: NUM_REGS=32, ADDR_W=5, REG_ZERO=5'd0.
  - typedef reg_word_t = logic [WIDTH-1:0]. This is fixed at 32 in the package, and the module parameter overrides it locally.
- Sub-module: reg_cell is natural. It holds one WIDTH-bit register with clk, rst (async clear) and ena (loads when high), and is instantiated 32 times by a generate loop, with ena=wsel[i].
- The existing decoder module is instantiated as is. Read muxes stay inline in regfile_32x32.

Test Plan:
- Reset: preload reg5=32'hDEADBEEF, then pulse rst asynchronously between edges -> rdata1 (raddr1=5) is 0 immediately, before the next clk edge.
- Basic write/read: we=1, waddr=7, wdata=32'h12345678, one edge -> rdata1 (raddr1=7) and rdata2 (raddr2=7) are both 32'h12345678. Other registers are unchanged, checked by a scan of all 32.
- we=0 hold: waddr=7, wdata=32'hFFFFFFFF, we=0, 3 edges -> reg7 stays 32'h12345678.
- R0 protection (ZERO_R0=1): write 32'hAAAA5555 to waddr=0 -> rdata1 with raddr1=0 is 0. With ZERO_R0=0, the same write reads back 32'hAAAA5555.
- Same-cycle read/write: reg3=32'h1, we=1, waddr=3, wdata=32'h2, raddr1=3 before the edge -> BYPASS=0 gives 32'h1, BYPASS=1 gives 32'h2. Both read 32'h2 after the edge.
- Walking write: write value i+100 to each i=1..31 on consecutive edges, then sweep raddr1/raddr2 in opposite orders -> every read returns i+100 and index 0 returns 0.
